// File: rtl/format_encoder_pkg.sv
// rtl/format_encoder_pkg.sv - shared types and widths for the posit encoder
package format_encoder_pkg;

  typedef enum logic {POS = 1'b0, NEG = 1'b1} sign_t;

  typedef struct packed {
    sign_t             sign;
    logic signed [7:0] regime;
    logic signed [7:0] exponent;
    logic [7:0]        mantissa;
    logic              is_zero;
    logic              is_nar;
  } posit_fields_t;

  localparam int MANT_BITS = 8;
  // Terminator plus mantissa: the bits past the body that feed guard/sticky.
  localparam int GS_BITS   = MANT_BITS + 1;

  function automatic int body_width(input int width, input int en);
    return width - 1 + en + GS_BITS;
  endfunction

endpackage

// File: rtl/format_encoder_if.sv
// rtl/format_encoder_if.sv - field input and posit output handshake bundle
interface format_encoder_if #(
  parameter int WIDTH = 7
);
  import format_encoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  sign_t             sign;
  logic signed [7:0] regime;
  logic signed [7:0] exponent;
  logic [7:0]        mantissa;
  logic              is_zero;
  logic              is_nar;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  posit;

  modport master (
    output in_valid, sign, regime, exponent, mantissa, is_zero, is_nar, out_ready,
    input  in_ready, out_valid, posit
  );

  modport slave (
    input  in_valid, sign, regime, exponent, mantissa, is_zero, is_nar, out_ready,
    output in_ready, out_valid, posit
  );

endinterface

// File: rtl/format_encoder_round.sv
// rtl/format_encoder_round.sv - posit_round_rne: RNE rounding of the body with posit saturation
module posit_round_rne
  import format_encoder_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int EN    = 1
) (
  input  logic [body_width(WIDTH, EN)-1:0] body,
  input  logic                             sat_hi,
  input  logic                             sat_lo,
  output logic [WIDTH-2:0]                 b
);

  localparam int BW = body_width(WIDTH, EN);
  localparam int NB = WIDTH - 1;

  logic [NB-1:0] b_t;
  logic          g;
  logic          s;
  logic          up;
  logic [NB:0]   sum;

  always_comb begin
    b_t = body[BW-1 -: NB];
    g   = body[BW-1-NB];
    s   = |body[BW-2-NB:0];
    up  = g & (s | b_t[0]);
    sum = {1'b0, b_t} + {{NB{1'b0}}, up};
    // Overflow clamps to maxpos; a nonzero value never collapses to zero.
    if (sum[NB] || sat_hi)
      b = '1;
    else if ((sum[NB-1:0] == '0) || sat_lo)
      b = NB'(1);
    else
      b = sum[NB-1:0];
  end

endmodule

// File: rtl/two_comp.sv
// rtl/two_comp.sv - two's complement negation
module two_comp #(
  parameter int WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = ~a + WIDTH'(1);

endmodule

// File: rtl/format_encoder.sv
// rtl/format_encoder.sv - two-stage posit encoder: regime expansion, then rounding and sign
module format_encoder
  import format_encoder_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int EN    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  format_encoder_if.slave bus
);

  localparam int BW = body_width(WIDTH, EN);
  localparam int TW = EN + GS_BITS;
  localparam int RW = $clog2(WIDTH + 1);
  localparam logic signed [7:0] K_MAX = 8'(WIDTH - 2);
  localparam logic signed [7:0] K_MIN = 8'(-(WIDTH - 1));
  localparam logic [7:0]        E_MASK = 8'((1 << EN) - 1);

  posit_fields_t     f;
  logic signed [7:0] k_c;
  logic              sat_hi, sat_lo;
  logic [RW-1:0]     run;
  logic [TW-1:0]     tw;
  logic [BW-1:0]     tail, body;

  logic              s1_valid, s2_valid, s2_adv, in_ready;
  logic [BW-1:0]     s1_body;
  logic              s1_sat_hi, s1_sat_lo, s1_neg, s1_zero, s1_nar;
  logic [WIDTH-2:0]  b_rnd;
  logic [WIDTH-1:0]  mag, mag_neg, p_next, posit_q;

  assign f = '{sign: bus.sign, regime: bus.regime, exponent: bus.exponent,
               mantissa: bus.mantissa, is_zero: bus.is_zero, is_nar: bus.is_nar};

  always_comb begin
    sat_hi = f.regime >= K_MAX;
    sat_lo = f.regime <= K_MIN;
    k_c    = sat_hi ? K_MAX : (sat_lo ? K_MIN : f.regime);
    run    = k_c[7] ? RW'(-k_c) : RW'(k_c + 8'sd1);
    // {terminator, exponent, mantissa}; the regime run is shifted in above it.
    tw     = TW'({1'b0, f.mantissa}) | TW'({8'(f.exponent) & E_MASK, 8'h00});
    tw[TW-1] = k_c[7];
    tail   = {tw, {(BW-TW){1'b0}}};
    body   = (tail >> run) | (k_c[7] ? '0 : ~({BW{1'b1}} >> run));
  end

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_body   <= '0;
      s1_sat_hi <= 1'b0;
      s1_sat_lo <= 1'b0;
      s1_neg    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_body   <= body;
        s1_sat_hi <= sat_hi;
        s1_sat_lo <= sat_lo;
        s1_neg    <= (f.sign == NEG);
        s1_zero   <= f.is_zero;
        s1_nar    <= f.is_nar;
      end
    end
  end

  posit_round_rne #(.WIDTH(WIDTH), .EN(EN)) u_round (
    .body   (s1_body),
    .sat_hi (s1_sat_hi),
    .sat_lo (s1_sat_lo),
    .b      (b_rnd)
  );

  assign mag = {1'b0, b_rnd};

  two_comp #(.WIDTH(WIDTH)) u_neg (
    .a (mag),
    .y (mag_neg)
  );

  always_comb begin
    if (s1_nar)
      p_next = {1'b1, {(WIDTH-1){1'b0}}};
    else if (s1_zero)
      p_next = '0;
    else
      p_next = s1_neg ? mag_neg : mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      posit_q  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid)
        posit_q <= p_next;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.posit     = posit_q;

endmodule
